register_scoreboard_controller: RTL
===================================

Name: register_scoreboard_controller

Overview:
- Tracks per-architectural-register pending-write status for the dual-issue front end (upper memory-capable slot, lower ALU slot).
- On issue, marks the destination busy and records its ageTag and whether it is a load. On result writeback, clears the entry only when the ageTag matches.
- Answers source-operand hazard lookups for both slots each cycle. Sits between the issuer and the ROB/writeback buses.

Parameters:
- REGISTER_COUNT, 32, number of architectural registers; register 0 is hardwired never-busy.
- TAG_WIDTH, 4, ageTag width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; clears all entries next edge.
- upperAllocate  input  1  upper slot issues an instruction writing upperDestination this cycle.
- upperDestination  input  5  destination register.
- upperAgeTag  input  TAG_WIDTH  ageTag of upper issue.
- upperIsLoad  input  1  upper issue is a load.
- lowerAllocate  input  1  lower slot issue (program-order younger than upper).
- lowerDestination  input  5  destination register.
- lowerAgeTag  input  TAG_WIDTH  ageTag of lower issue.
- clearValid  input  2  per-writeback-port result valid (port 0 = upper pipe, port 1 = lower pipe).
- clearDestination  input  10  two packed 5-bit destinations, port 0 in bits [4:0].
- clearAgeTag  input  2*TAG_WIDTH  two packed ageTags, port 0 in the low bits.
- lookupRegister  input  20  four packed 5-bit sources: [upper rs1, upper rs2, lower rs1, lower rs2], low to high.
- lookupBusy  output  4  busy bit per lookup.
- lookupIsLoad  output  4  isLoad bit per lookup.
- lookupAgeTag  output  4*TAG_WIDTH  producing ageTag per lookup.
- intraPairHazard  output  1  a lower source equals upperDestination while upperAllocate=1 and upperDestination!=0.
- busyCount  output  6  number of busy entries.

Behaviour:
- Reset (async, reset=0): all entries busy=0, isLoad=0, ageTag=0; busyCount=0; lookup outputs 0. intraPairHazard is combinational and still follows its inputs.
- Lookup outputs are combinational from registered state. There is no same-cycle bypass of clears or allocates; latency is 1 cycle from an allocate or clear edge to its visibility.
- Lookup of register 0 always returns busy=0, isLoad=0, tag=0.
- Allocate: at the clock edge, the entry gets busy=1, the given ageTag, and isLoad (lower slot always writes isLoad=0). Allocates to register 0 are ignored.
- Clear: at the clock edge, if clearValid[i], the entry is busy, and the stored ageTag equals clearAgeTag[i], set busy=0 and isLoad=0. The tag is retained. A tag mismatch is ignored, because a younger writer owns the entry.
- Priority per entry, highest first: flush, lowerAllocate, upperAllocate, clear.
  - Upper and lower allocating the same register: lower wins, since it is younger.
  - Allocate and matching clear to the same register in the same cycle: allocate wins, and the entry stays busy with the new tag.
  - Two clear ports hitting the same register: either matching port clears; result is identical.
- flush: all entries go to the reset state at the next edge. Allocates and clears in that cycle are discarded.
- busyCount: registered popcount of the next-state busy vector, so it reflects state after the edge. Range 0..31.

Test Plan:
- Reset then lookup r5 -> lookupBusy=0, busyCount=0. Upper allocate r5 tag 3 isLoad=1 -> next cycle upper rs1=r5 gives busy=1, isLoad=1, tag=3, busyCount=1.
- With r5 busy tag 3: clear port 1 r5 tag 2 -> stays busy. Clear r5 tag 3 -> busy=0, busyCount=0.
- Upper allocates r7 tag 1 and lower allocates r7 tag 2 in the same cycle -> r7 tag=2, isLoad=0. A later clear r7 tag 1 leaves it busy.
- r9 busy tag 4: same cycle, clear r9 tag 4 and upper allocate r9 tag 6 -> r9 busy, tag 6.
- Allocate r0 -> lookup r0 busy=0, busyCount unchanged. Upper allocate r3 with lower rs2=r3 -> intraPairHazard=1 same cycle; with upperDestination=r0 -> 0.
- Fill r1..r31 -> busyCount=31. Assert flush together with an allocate of r2 -> all busy=0, busyCount=0. Assert reset low mid-sequence -> state clears immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_scoreboard_controller_if.sv
// Issue / writeback / lookup bundle between the dual-issue front end and the register scoreboard.
// The master side is the issuer plus the writeback buses; the slave side is the scoreboard.
interface register_scoreboard_controller_if #(
    parameter int TAG_WIDTH = 4
);
    logic                     flush;
    logic                     upperAllocate;
    logic [4:0]               upperDestination;
    logic [TAG_WIDTH-1:0]     upperAgeTag;
    logic                     upperIsLoad;
    logic                     lowerAllocate;
    logic [4:0]               lowerDestination;
    logic [TAG_WIDTH-1:0]     lowerAgeTag;
    logic [1:0]               clearValid;
    logic [9:0]               clearDestination;
    logic [2*TAG_WIDTH-1:0]   clearAgeTag;
    logic [19:0]              lookupRegister;
    logic [3:0]               lookupBusy;
    logic [3:0]               lookupIsLoad;
    logic [4*TAG_WIDTH-1:0]   lookupAgeTag;
    logic                     intraPairHazard;
    logic [5:0]               busyCount;

    modport master (
        output flush, upperAllocate, upperDestination, upperAgeTag, upperIsLoad,
               lowerAllocate, lowerDestination, lowerAgeTag,
               clearValid, clearDestination, clearAgeTag, lookupRegister,
        input  lookupBusy, lookupIsLoad, lookupAgeTag, intraPairHazard, busyCount
    );

    modport slave (
        input  flush, upperAllocate, upperDestination, upperAgeTag, upperIsLoad,
               lowerAllocate, lowerDestination, lowerAgeTag,
               clearValid, clearDestination, clearAgeTag, lookupRegister,
        output lookupBusy, lookupIsLoad, lookupAgeTag, intraPairHazard, busyCount
    );
endinterface

// File: rtl/register_scoreboard_controller.sv
// Per-register pending-write scoreboard for a dual-issue front end: tracks busy/isLoad/ageTag
// per architectural register and answers four source-operand lookups per cycle.
module register_scoreboard_controller #(
    parameter int REGISTER_COUNT = 32,
    parameter int TAG_WIDTH      = 4
) (
    input logic                             clock,
    input logic                             reset,
    register_scoreboard_controller_if.slave bus
);
    localparam int REG_W = 5;
    localparam int LOOKUPS = 4;

    typedef logic [TAG_WIDTH-1:0] tag_t;

    logic [REGISTER_COUNT-1:0] busy_q;
    logic [REGISTER_COUNT-1:0] busy_d;
    logic [REGISTER_COUNT-1:0] is_load_q;
    logic [REGISTER_COUNT-1:0] is_load_d;
    tag_t                      tag_q [REGISTER_COUNT];
    tag_t                      tag_d [REGISTER_COUNT];
    logic [5:0]                busy_count_q;

    function automatic logic [5:0] popcount(input logic [REGISTER_COUNT-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < REGISTER_COUNT; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    // Next-state: clear, then upper allocate, then lower allocate, then flush, so later wins.
    always_comb begin
        busy_d    = busy_q;
        is_load_d = is_load_q;
        tag_d     = tag_q;
        for (int r = 1; r < REGISTER_COUNT; r++) begin
            for (int p = 0; p < 2; p++) begin
                if (bus.clearValid[p] &&
                    bus.clearDestination[p*REG_W +: REG_W] == REG_W'(r) &&
                    busy_q[r] &&
                    tag_q[r] == bus.clearAgeTag[p*TAG_WIDTH +: TAG_WIDTH]) begin
                    busy_d[r]    = 1'b0;
                    is_load_d[r] = 1'b0;
                end
            end
            if (bus.upperAllocate && bus.upperDestination == REG_W'(r)) begin
                busy_d[r]    = 1'b1;
                is_load_d[r] = bus.upperIsLoad;
                tag_d[r]     = bus.upperAgeTag;
            end
            if (bus.lowerAllocate && bus.lowerDestination == REG_W'(r)) begin
                busy_d[r]    = 1'b1;
                is_load_d[r] = 1'b0;
                tag_d[r]     = bus.lowerAgeTag;
            end
        end
        if (bus.flush) begin
            busy_d    = '0;
            is_load_d = '0;
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                tag_d[r] = '0;
            end
        end
    end

    // State registers; busy_count tracks the post-edge busy vector.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q       <= '0;
            is_load_q    <= '0;
            busy_count_q <= '0;
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            is_load_q    <= is_load_d;
            busy_count_q <= popcount(busy_d);
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                tag_q[r] <= tag_d[r];
            end
        end
    end

    // Lookups read registered state only; register 0 always reads as idle.
    always_comb begin
        bus.lookupBusy   = '0;
        bus.lookupIsLoad = '0;
        bus.lookupAgeTag = '0;
        for (int k = 0; k < LOOKUPS; k++) begin
            logic [REG_W-1:0] src;
            src = bus.lookupRegister[k*REG_W +: REG_W];
            if (src != '0 && int'(src) < REGISTER_COUNT) begin
                bus.lookupBusy[k]                          = busy_q[src];
                bus.lookupIsLoad[k]                        = is_load_q[src];
                bus.lookupAgeTag[k*TAG_WIDTH +: TAG_WIDTH] = tag_q[src];
            end
        end
    end

    assign bus.intraPairHazard = bus.upperAllocate && (bus.upperDestination != '0) &&
                                 ((bus.lookupRegister[2*REG_W +: REG_W] == bus.upperDestination) ||
                                  (bus.lookupRegister[3*REG_W +: REG_W] == bus.upperDestination));

    assign bus.busyCount = busy_count_q;

endmodule
